// File: rtl/frase_pkg.sv
// Shared types for the phrase RAM stream reader.
// Holds the reader FSM state encoding and the NUL terminator value.
package frase_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } frase_rd_state_t;

    localparam logic [7:0] NUL_CHAR = 8'h00;

endpackage

// File: rtl/frase_stream_reader_if.sv
// Bus bundle between the stream reader, the data RAM read port,
// the command source (start/base_addr/length) and the character consumer.
//   master: the reader (drives address, char_out, char_valid, busy, done)
//   slave : the environment (drives start, base_addr, length, q, char_ready)
interface frase_stream_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 9
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] char_out;
    logic              char_valid;
    logic              char_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, length, q, char_ready,
        output address, char_out, char_valid, busy, done
    );

    modport slave (
        output start, base_addr, length, q, char_ready,
        input  address, char_out, char_valid, busy, done
    );
endinterface

// File: rtl/frase_stream_reader.sv
// Read-side master for the phrase data RAM: walks base_addr..base_addr+length-1
// (wrapping) through the RAM address/q port and streams characters over
// char_valid/char_ready. Ports: clock, reset (sync, active-high), bus (master).
// Optional: STOP_ON_NUL_EN ends a transfer when a NUL is fetched.
module frase_stream_reader
    import frase_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic                    clock,
    input  logic                    reset,
    frase_stream_reader_if.master   bus
);

    frase_rd_state_t   r_state;
    frase_rd_state_t   w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_char;
    logic [DATA_W-1:0] w_char_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  w_count_nxt;
    logic              r_busy;
    logic              r_done;
    logic              w_stop;

`ifdef STOP_ON_NUL_EN
    assign w_stop = (bus.q == DATA_W'(NUL_CHAR));
`else
    assign w_stop = 1'b0;
`endif

    // r_count holds the characters still to send after the current one.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_char_nxt  = r_char;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        w_state_nxt = FETCH;
                        w_addr_nxt  = bus.base_addr;
                        w_count_nxt = bus.length - LEN_W'(1);
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            FETCH: begin
                if (w_stop) begin
                    w_state_nxt = DONE;
                end else begin
                    w_char_nxt  = bus.q;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (r_valid && bus.char_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_count == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_count_nxt = r_count - LEN_W'(1);
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up with r_state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_char  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_char  <= w_char_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            r_busy  <= (w_state_nxt == FETCH) || (w_state_nxt == SEND);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign bus.address    = r_addr;
    assign bus.char_out   = r_char;
    assign bus.char_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_frase_stream_reader.sv
// Self-checking bench for frase_stream_reader against a 256-byte RAM model.
// Expected characters come from walking the RAM array with modular arithmetic.
module tb_frase_stream_reader;
    import frase_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] ram [256];

    frase_stream_reader_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) m_if ();

    frase_stream_reader #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (m_if.master)
    );

    assign m_if.q = ram[m_if.address];

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: stall 5 cycles on char 2
    task automatic run_xfer(input logic [7:0] base, input logic [8:0] len,
                            input int mode, input bit start_busy);
        logic [7:0] exp_c[$];
        logic [7:0] exp_a[$];
        logic [7:0] a;
        logic [7:0] prev_c;
        logic [7:0] prev_a;
        bit         nul_stop;
        bit         prev_pend;
        bit         seen_done;
        int         edges;
        int         stall;
        int         hs;
        nul_stop  = 0;
        prev_pend = 0;
        seen_done = 0;
        stall     = 0;
        hs        = 0;
        prev_c    = '0;
        prev_a    = '0;
        for (int i = 0; i < int'(len); i++) begin
            a = 8'((int'(base) + i) % 256);
`ifdef STOP_ON_NUL_EN
            if (ram[a] == 8'h00) begin
                nul_stop = 1;
                break;
            end
`endif
            exp_c.push_back(ram[a]);
            exp_a.push_back(a);
        end
        @(negedge clock);
        m_if.start      = 1'b1;
        m_if.base_addr  = base;
        m_if.length     = len;
        m_if.char_ready = 1'b1;
        @(negedge clock);
        m_if.start = 1'b0;
        edges = 1;
        for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
            if (m_if.done) begin
                seen_done = 1;
                check("sent_count", hs, exp_c.size());
                if (mode == 0)
                    check("done_edge", edges, 2 * exp_c.size() + 1 + int'(nul_stop));
            end else begin
                if (prev_pend) begin
                    check("hold_valid", m_if.char_valid, 1'b1);
                    check("hold_char", m_if.char_out, prev_c);
                    check("hold_addr", m_if.address, prev_a);
                end
                case (mode)
                    0: m_if.char_ready = 1'b1;
                    1: m_if.char_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (m_if.char_valid && hs == 1 && stall < 5) begin
                            m_if.char_ready = 1'b0;
                            stall++;
                        end else begin
                            m_if.char_ready = 1'b1;
                        end
                    end
                endcase
                if (start_busy && edges == 3) begin
                    check("busy_at_start", m_if.busy, 1'b1);
                    m_if.start     = 1'b1;
                    m_if.base_addr = ~base;
                    m_if.length    = 9'd5;
                end else begin
                    m_if.start = 1'b0;
                end
                if (m_if.char_valid && m_if.char_ready) begin
                    if (hs < exp_c.size()) begin
                        check("char", m_if.char_out, exp_c[hs]);
                        check("addr", m_if.address, exp_a[hs]);
                    end else begin
                        check("extra_char", hs, exp_c.size());
                    end
                    hs++;
                    prev_pend = 0;
                end else if (m_if.char_valid) begin
                    prev_pend = 1;
                    prev_c    = m_if.char_out;
                    prev_a    = m_if.address;
                end else begin
                    prev_pend = 0;
                end
                @(negedge clock);
                edges++;
            end
        end
        check("done_seen", seen_done, 1'b1);
        if (!seen_done) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end
        // start during the DONE cycle must be ignored
        m_if.start      = 1'b1;
        m_if.length     = 9'd3;
        m_if.char_ready = 1'b1;
        @(negedge clock);
        m_if.start = 1'b0;
        check("done_pulse_one", m_if.done, 1'b0);
        check("idle_after_done", m_if.busy, 1'b0);
        @(negedge clock);
        check("start_in_done_ignored", m_if.busy, 1'b0);
    endtask

    initial begin
        m_if.start      = 1'b0;
        m_if.base_addr  = '0;
        m_if.length     = '0;
        m_if.char_ready = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom_range(1, 255));
        ram[8'h00] = "H"; ram[8'h01] = "O"; ram[8'h02] = "L"; ram[8'h03] = "A";
        ram[8'h10] = "X"; ram[8'h11] = "Y"; ram[8'h12] = "Z";
        ram[8'hFE] = "w"; ram[8'hFF] = "x"; ram[8'h04] = "y";
        ram[8'h40] = "A"; ram[8'h41] = "B"; ram[8'h42] = 8'h00; ram[8'h43] = "C";

        // reset state
        repeat (2) @(negedge clock);
        check("rst_addr", m_if.address, 8'h00);
        check("rst_char", m_if.char_out, 8'h00);
        check("rst_valid", m_if.char_valid, 1'b0);
        check("rst_busy", m_if.busy, 1'b0);
        check("rst_done", m_if.done, 1'b0);
        reset = 1'b0;

        // reset mid-SEND after two characters
        m_if.char_ready = 1'b1;
        @(negedge clock);
        m_if.start     = 1'b1;
        m_if.base_addr = 8'h00;
        m_if.length    = 9'd4;
        @(negedge clock);
        m_if.start = 1'b0;
        repeat (5) @(negedge clock);
        check("midsend_valid", m_if.char_valid, 1'b1);
        check("midsend_char", m_if.char_out, 8'h4C);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mr_addr", m_if.address, 8'h00);
        check("mr_char", m_if.char_out, 8'h00);
        check("mr_valid", m_if.char_valid, 1'b0);
        check("mr_busy", m_if.busy, 1'b0);
        check("mr_done", m_if.done, 1'b0);
        check("mr_state", dut.r_state, IDLE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("mr_no_done", m_if.done, 1'b0);
        end

        // HOLA, ready always high
        run_xfer(8'h00, 9'd4, 0, 1'b0);
        // stall on the second character
        run_xfer(8'h10, 9'd3, 2, 1'b0);
        // address wrap
        run_xfer(8'hFE, 9'd4, 0, 1'b0);
        // zero length
        run_xfer(8'h20, 9'd0, 0, 1'b0);
        // start while busy
        run_xfer(8'h30, 9'd4, 0, 1'b1);
        // embedded NUL
        run_xfer(8'h40, 9'd4, 0, 1'b0);
        run_xfer(8'h40, 9'd4, 1, 1'b0);
        // length beyond the RAM size
        run_xfer(8'h80, 9'd300, 0, 1'b0);
        // random transfers
        for (int t = 0; t < 10; t++) begin
            run_xfer(8'($urandom_range(0, 255)), 9'($urandom_range(1, 20)),
                     1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
